// File: rtl/p2s_rr_scheduler.sv
// p2s_rr_scheduler: round-robin arbiter sharing one 4-bit parallel-to-serial
// converter among NUM_REQ requesters. It grants one requester, loads its
// nibble into the converter, waits for the converter to drain, and pulses
// frame_done. If the converter never drains, a watchdog pulses err instead.
//
// Handshake: a requester raises req[i] with its nibble stable on req_data and
// holds both until it sees a one-cycle ack[i]. The nibble is captured on the
// edge that raises ack[i]. Dropping req[i] before ack withdraws the request.
module p2s_rr_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int ID_W        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 ser_load,
    output logic [3:0]           ser_p_data,
    input  logic                 ser_empty,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 frame_done,
    output logic                 err,
    output logic [1:0]           dbg_state_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 load_q, load_d;
    logic [3:0]           pdata_q, pdata_d;
    logic                 busy_q, busy_d;
    logic [ID_W-1:0]      gid_q, gid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    logic [ID_W-1:0]      cand;

    // Index base+off wrapped into 0..NUM_REQ-1 (works for non power-of-two NUM_REQ).
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    // Round-robin winner search: first set request starting at ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_idx(ptr_q, k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/LOAD/SHIFT FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        load_d  = 1'b0;
        pdata_d = pdata_q;
        busy_d  = busy_q;
        gid_d   = gid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (en && ser_empty && win_found) begin
                    ack_d[win_idx] = 1'b1;
                    load_d         = 1'b1;
                    pdata_d        = req_data[4*win_idx +: 4];
                    gid_d          = win_idx;
                    busy_d         = 1'b1;
                    ptr_d          = wrap_idx(win_idx, 1);
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                // The converter samples ser_load at the end of this cycle.
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                // Count 0 is the first SHIFT cycle: empty is still stale there.
                if ((cnt_q != '0) && ser_empty) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            pdata_q <= '0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            pdata_q <= pdata_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack         = ack_q;
    assign ser_load    = load_q;
    assign ser_p_data  = pdata_q;
    assign busy        = busy_q;
    assign grant_id    = gid_q;
    assign frame_done  = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Directed bench for p2s_rr_scheduler with a small behavioural model of the
// 4-bit parallel-to-serial converter (LSB first, 4 valid cycles, then empty).
module tb_p2s_rr_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int ID_W        = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 ser_load;
    logic [3:0]           ser_p_data;
    logic                 ser_empty;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 frame_done;
    logic                 err;
    logic [1:0]           dbg_state;

    int checks = 0;
    int errors = 0;
    logic [ID_W-1:0] exp_q[$];

    // Converter model
    logic [2:0] conv_cnt;
    logic [3:0] conv_sh;
    logic       force_full;
    logic       ser_out;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Converter: loads on ser_load, shifts out 4 bits LSB first, then empty.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_cnt <= 3'd0;
            conv_sh  <= 4'd0;
        end else if (ser_load) begin
            conv_cnt <= 3'd4;
            conv_sh  <= ser_p_data;
        end else if (conv_cnt != 3'd0) begin
            conv_cnt <= conv_cnt - 3'd1;
            conv_sh  <= conv_sh >> 1;
        end
    end

    assign ser_empty = (conv_cnt == 3'd0) && !force_full;
    assign ser_out   = conv_sh[0];

    p2s_rr_scheduler #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .ser_load(ser_load),
        .ser_p_data(ser_p_data),
        .ser_empty(ser_empty),
        .busy(busy),
        .grant_id(grant_id),
        .frame_done(frame_done),
        .err(err),
        .dbg_state_o(dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b0;
        req        = '0;
        req_data   = '0;
        force_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst        = 1'b1;
        en         = 1'b0;
        req        = '0;
        req_data   = '0;
        force_full = 1'b0;
        tick();
        tick();
        checks++;
        if ({ack, ser_load, ser_p_data, busy, grant_id, frame_done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b load=%b pd=%h busy=%b gid=%0d done=%b err=%b want all 0",
                     ack, ser_load, ser_p_data, busy, grant_id, frame_done, err);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", dbg_state);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] d;
        d        = 4'hA;
        en       = 1'b1;
        req_data = {12'h000, d};
        req      = 4'b0001;
        tick();                                       // cycle 1 (LOAD)
        checks++;
        if (ack !== 4'b0001) begin errors++; $display("FAIL t1_ack got %b want 0001", ack); end
        checks++;
        if (ser_load !== 1'b1) begin errors++; $display("FAIL t1_load got %b want 1", ser_load); end
        checks++;
        if (ser_p_data !== d) begin errors++; $display("FAIL t1_pdata got %h want %h", ser_p_data, d); end
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL t1_grant got gid=%0d busy=%b want gid=0 busy=1", grant_id, busy);
        end
        req = '0;
        tick();                                       // cycle 2
        checks++;
        if (ack !== 4'b0000 || ser_load !== 1'b0) begin
            errors++; $display("FAIL t1_pulse_len got ack=%b load=%b want 0000 0", ack, ser_load);
        end
        for (int i = 0; i < 4; i++) begin             // cycles 2..5
            checks++;
            if (ser_out !== d[i] || ser_empty !== 1'b0) begin
                errors++; $display("FAIL t1_serial bit%0d got %b empty=%b want %b empty=0", i, ser_out, ser_empty, d[i]);
            end
            tick();
        end
        checks++;                                     // cycle 6
        if (frame_done !== 1'b0 || busy !== 1'b1 || ser_empty !== 1'b1) begin
            errors++; $display("FAIL t1_c6 got done=%b busy=%b empty=%b want 0 1 1", frame_done, busy, ser_empty);
        end
        tick();                                       // cycle 7
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL t1_done got done=%b busy=%b st=%0d want 1 0 0", frame_done, busy, dbg_state);
        end
        tick();                                       // cycle 8
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL t1_done_once got %b want 0", frame_done); end
    endtask

    task automatic test_contention();
        int extra_acks;
        logic [ID_W-1:0] want;
        logic [NUM_REQ-1:0] want_ack;
        do_reset();
        en       = 1'b1;
        req_data = 16'h4321;
        req      = 4'b1111;
        exp_q    = {};
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        for (int g = 0; g < 5; g++) begin
            tick();                                   // grant visible
            want     = exp_q.pop_front();
            want_ack = 4'b0001 << want;
            checks++;
            if (ack !== want_ack || grant_id !== want) begin
                errors++; $display("FAIL t2_grant%0d got ack=%b gid=%0d want ack=%b gid=%0d", g, ack, grant_id, want_ack, want);
            end
            checks++;
            if (ser_p_data !== 4'(want) + 4'd1 || ser_load !== 1'b1) begin
                errors++; $display("FAIL t2_data%0d got pd=%h load=%b want pd=%h load=1", g, ser_p_data, ser_load, 4'(want) + 4'd1);
            end
            if (g == 4) req = '0;
            extra_acks = 0;
            for (int c = 2; c <= 7; c++) begin
                tick();
                if (ack !== '0) extra_acks++;
                if (c == 7) begin
                    checks++;
                    if (frame_done !== 1'b1 || busy !== 1'b0) begin
                        errors++; $display("FAIL t2_done%0d got done=%b busy=%b want 1 0", g, frame_done, busy);
                    end
                end
            end
            checks++;
            if (extra_acks != 0) begin
                errors++; $display("FAIL t2_acks%0d got %0d extra acks want 0", g, extra_acks);
            end
        end
    endtask

    task automatic test_fairness();
        logic [ID_W-1:0] want;
        do_reset();
        en       = 1'b1;
        req_data = 16'hC560;                          // data3=C, data2=5, data1=6
        req      = 4'b0100;
        exp_q    = {};
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        for (int g = 0; g < 3; g++) begin
            tick();
            want = exp_q.pop_front();
            checks++;
            if (grant_id !== want || ack !== (4'b0001 << want)) begin
                errors++; $display("FAIL t3_grant%0d got gid=%0d ack=%b want gid=%0d", g, grant_id, ack, want);
            end
            checks++;
            if (ser_p_data !== req_data[4*want +: 4]) begin
                errors++; $display("FAIL t3_data%0d got %h want %h", g, ser_p_data, req_data[4*want +: 4]);
            end
            if (g == 0) req = 4'b1010;
            else req[want] = 1'b0;                    // requester drops on ack
            for (int c = 2; c <= 7; c++) tick();
        end
    endtask

    task automatic test_watchdog();
        int bad;
        en       = 1'b1;
        req_data = 16'h0009;
        req      = 4'b0001;
        tick();                                       // cycle 1 (LOAD)
        checks++;
        if (ack !== 4'b0001) begin errors++; $display("FAIL t4_ack got %b want 0001", ack); end
        req        = '0;
        force_full = 1'b1;
        bad        = 0;
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (err !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t4_wait got %0d bad cycles want 0", bad); end
        tick();                                       // cycle 18
        checks++;
        if (err !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL t4_err got err=%b done=%b busy=%b st=%0d want 1 0 0 0", err, frame_done, busy, dbg_state);
        end
        force_full = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL t4_err_once got %b want 0", err); end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        do_reset();
        en       = 1'b1;
        req_data = 16'h0300;
        req      = 4'b0100;                           // grant 2, ptr moves to 3
        tick();
        req = '0;
        tick();
        tick();                                       // cycle 3, SHIFT
        rst = 1'b1;
        #1;
        checks++;
        if ({ack, ser_load, ser_p_data, busy, grant_id, frame_done, err} !== '0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL t5_async got ack=%b load=%b pd=%h busy=%b gid=%0d done=%b err=%b st=%0d want all 0",
                               ack, ser_load, ser_p_data, busy, grant_id, frame_done, err, dbg_state);
        end
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack !== '0 || frame_done !== 1'b0 || err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t5_quiet got %0d pulse cycles want 0", bad); end
        req_data = 16'h5300;
        req      = 4'b1100;                           // ptr=0 picks 2, a stale ptr=3 would pick 3
        tick();
        checks++;
        if (grant_id !== 2'd2 || ack !== 4'b0100 || ser_p_data !== 4'h3) begin
            errors++; $display("FAIL t5_regrant got gid=%0d ack=%b pd=%h want 2 0100 3", grant_id, ack, ser_p_data);
        end
        req = '0;
        for (int c = 2; c <= 7; c++) tick();
    endtask

    task automatic test_en_gating();
        int bad;
        en       = 1'b0;
        req_data = 16'h000E;
        req      = 4'b0001;
        bad      = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack !== '0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t6_gated got %0d grant cycles want 0", bad); end
        en = 1'b1;
        tick();                                       // cycle 1
        checks++;
        if (ack !== 4'b0001 || ser_p_data !== 4'hE) begin
            errors++; $display("FAIL t6_grant got ack=%b pd=%h want 0001 e", ack, ser_p_data);
        end
        tick();                                       // cycle 2
        en = 1'b0;
        for (int c = 3; c <= 7; c++) tick();
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL t6_finish got done=%b busy=%b want 1 0", frame_done, busy);
        end
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack !== '0 || busy !== 1'b0 || ser_load !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL t6_hold got %0d grant cycles want 0", bad); end
        en = 1'b1;
        tick();
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b1) begin
            errors++; $display("FAIL t6_resume got ack=%b busy=%b want 0001 1", ack, busy);
        end
        req = '0;
        for (int c = 2; c <= 7; c++) tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        req        = '0;
        req_data   = '0;
        force_full = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_watchdog();
        test_reset_mid_frame();
        test_en_gating();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
